// File: rtl/grant_dispatch_pkg.sv
// grant_dispatch_pkg: shared types and helpers for the grant dispatcher.
// Optional statistics counters are enabled with GRANT_DISPATCH_STATS_EN.
package grant_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Width of the per-port statistics counters
    localparam int STAT_W = 16;

    // Port index width; never narrower than one bit
    function automatic int PORT_IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/onehot_to_idx.sv
// onehot_to_idx: combinational one-hot to binary encoder with a one-hot flag.
// For a multi-hot input the index is the OR of the set positions and is
// meaningless; callers qualify it with o_onehot.
module onehot_to_idx #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_onehot
);

    // OR together the indices of all set bits
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) o_idx = o_idx | IDX_W'(i);
        end
    end

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign o_onehot = (i_vec != '0) && ((i_vec & (i_vec - N'(1))) == '0);

endmodule

// File: rtl/grant_dispatcher.sv
// grant_dispatcher: locks onto the arbiter's one-hot grant and moves one burst
// of valid/ready beats from the winning port to a registered output channel.
// Define GRANT_DISPATCH_STATS_EN to add per-port burst / forced-end counters.
module grant_dispatcher
    import grant_dispatch_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_PORTS-1:0]              grant,
    input  logic [N_PORTS-1:0]              in_valid,
    input  logic [N_PORTS*DATA_W-1:0]       in_data,
    input  logic [N_PORTS-1:0]              in_last,
    output logic [N_PORTS-1:0]              in_ready,
    output logic                            out_valid,
    output logic [DATA_W-1:0]               out_data,
    output logic                            out_last,
    output logic [PORT_IDX_W(N_PORTS)-1:0]  out_port,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            burst_done,
`ifdef GRANT_DISPATCH_STATS_EN
    output logic [N_PORTS*STAT_W-1:0]       stat_bursts,
    output logic [N_PORTS*STAT_W-1:0]       stat_forced,
`endif
    output logic                            grant_err
);

    localparam int         IDX_W    = PORT_IDX_W(N_PORTS);
    localparam logic [7:0] LAST_CNT = 8'(MAX_BEATS - 1);

    state_e              r_state, w_next_state;
    logic [IDX_W-1:0]    r_sel;
    logic [7:0]          r_beat_cnt;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_last;
    logic [IDX_W-1:0]    r_out_port;
    logic                r_grant_err;

    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_gnt_onehot;
    logic [DATA_W-1:0]   w_sel_data;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic                w_beat_last;
    logic                w_accept;
    logic                w_burst_done;
    logic [N_PORTS-1:0]  w_in_ready;

    onehot_to_idx #(
        .N     (N_PORTS),
        .IDX_W (IDX_W)
    ) u_gnt_enc (
        .i_vec    (grant),
        .o_idx    (w_gnt_idx),
        .o_onehot (w_gnt_onehot)
    );

    // Select the locked port's valid/data/last
    always_comb begin
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_sel == IDX_W'(i)) begin
                w_sel_data  = in_data[i*DATA_W +: DATA_W];
                w_sel_valid = in_valid[i];
                w_sel_last  = in_last[i];
            end
        end
    end

    // A beat closes the burst on its own last flag or on reaching MAX_BEATS
    assign w_beat_last = w_sel_last || (r_beat_cnt == LAST_CNT);

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = '0;
        w_accept     = 1'b0;
        w_burst_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_onehot) w_next_state = XFER;
            end
            XFER: begin
                w_in_ready[r_sel] = !r_out_valid || out_ready;
                w_accept          = w_sel_valid && w_in_ready[r_sel];
                if (w_accept && w_beat_last) w_next_state = DRAIN;
            end
            DRAIN: begin
                if (r_out_valid && out_ready) begin
                    w_burst_done = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;
    end

    // Port lock, beat counter, output register and grant error pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel       <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_port  <= '0;
            r_grant_err <= 1'b0;
        end else begin
            r_grant_err <= (r_state == IDLE) && (grant != '0) && !w_gnt_onehot;
            if (r_state == IDLE && w_gnt_onehot) begin
                r_sel      <= w_gnt_idx;
                r_beat_cnt <= '0;
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_last  <= w_beat_last;
                r_out_port  <= r_sel;
                r_beat_cnt  <= r_beat_cnt + 8'd1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_last   = r_out_last;
    assign out_port   = r_out_port;
    assign busy       = (r_state != IDLE);
    assign burst_done = w_burst_done;
    assign grant_err  = r_grant_err;

`ifdef GRANT_DISPATCH_STATS_EN
    logic                            r_forced;
    logic [N_PORTS-1:0][STAT_W-1:0]  r_stat_bursts;
    logic [N_PORTS-1:0][STAT_W-1:0]  r_stat_forced;

    // Saturating per-port counters, bumped as the final beat leaves the output
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_forced      <= 1'b0;
            r_stat_bursts <= '0;
            r_stat_forced <= '0;
        end else begin
            if (w_accept && w_beat_last) r_forced <= !w_sel_last;
            if (w_burst_done) begin
                if (r_stat_bursts[r_out_port] != '1)
                    r_stat_bursts[r_out_port] <= r_stat_bursts[r_out_port] + STAT_W'(1);
                if (r_forced && (r_stat_forced[r_out_port] != '1))
                    r_stat_forced[r_out_port] <= r_stat_forced[r_out_port] + STAT_W'(1);
            end
        end
    end

    assign stat_bursts = r_stat_bursts;
    assign stat_forced = r_stat_forced;
`endif

endmodule

// File: doc/grant_dispatcher.md
Name: grant_dispatcher

Overview:
Downstream consumer of the 4-port round-robin arbiter's one-hot grant. On each grant it locks onto the winning port and moves one burst of valid/ready beats from that port to a single registered output channel. It then returns to idle so the arbiter's next grant can be serviced. It converts the arbiter's per-cycle grant into a burst-granular, flow-controlled data path.

Parameters:
N_PORTS, 4, number of requester ports; must match the arbiter width
DATA_W, 32, payload width per beat
MAX_BEATS, 8, forced burst termination length; 1..255

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
grant  in  N_PORTS  one-hot grant from the arbiter; all-zero means no grant
in_valid  in  N_PORTS  per-port beat valid
in_data  in  N_PORTS*DATA_W  per-port payload; port i occupies bits [i*DATA_W +: DATA_W]
in_last  in  N_PORTS  per-port last-beat marker
in_ready  out  N_PORTS  per-port ready; at most one bit high
out_valid  out  1  output beat valid, registered
out_data  out  DATA_W  output payload, registered
out_last  out  1  output last marker, registered
out_port  out  $clog2(N_PORTS)  index of the source port of the current output beat
out_ready  in  1  downstream ready
busy  out  1  high in XFER and DRAIN
burst_done  out  1  one-cycle pulse when the final beat of a burst leaves the output register
grant_err  out  1  one-cycle pulse when a sampled grant is not one-hot

Behaviour:
- Reset (rst_n low at clk edge): state=IDLE, sel=0, beat_cnt=0, out_valid=0, out_data=0, out_last=0, out_port=0, in_ready=0, busy=0, burst_done=0, grant_err=0. Reset mid-burst discards any held beat and performs no drain.
- FSM states: IDLE, XFER, DRAIN.
- IDLE:
  - grant is sampled every cycle; in_ready=0.
  - If grant is exactly one-hot: sel=index of the set bit, beat_cnt=0, next state XFER.
  - If grant has 2 or more bits set: pulse grant_err next cycle and stay in IDLE.
  - grant=0: stay in IDLE.
- XFER:
  - grant is ignored; the port is held until the burst ends.
  - in_ready[sel] = !out_valid || out_ready (combinational). All other in_ready bits are 0.
  - Accept = in_valid[sel] && in_ready[sel].
  - On accept: the output register loads in_data[sel], out_port=sel, out_valid=1, beat_cnt increments, and out_last = in_last[sel] || (beat_cnt==MAX_BEATS-1).
  - An accepted beat with out_last=1 moves the FSM to DRAIN.
  - If out_ready && out_valid and no accept occurs in the same cycle, out_valid clears.
- Forced termination: beat MAX_BEATS carries out_last=1 even if in_last[sel]=0. The source's remaining beats wait for a later grant.
- DRAIN:
  - in_ready=0.
  - When out_valid && out_ready: out_valid clears, burst_done pulses in the same cycle, next state IDLE.
- Throughput: 1 beat/cycle sustained while out_ready=1. Latency from input accept to out_valid is 1 cycle. The minimum grant-to-next-grant-sample gap is burst length + 2 cycles.
- Backpressure: when out_ready=0 with out_valid=1, the output register is held stable (data, last, port) and in_ready[sel]=0.
- in_valid on non-selected ports never causes an accept.

Optional Feature:
GRANT_DISPATCH_STATS_EN
- Defined: adds outputs stat_bursts[N_PORTS*16] and stat_forced[N_PORTS*16].
  - Per-port saturating 16-bit counters, cleared by reset.
  - stat_bursts increments on each burst_done for out_port.
  - stat_forced increments when a burst ends by MAX_BEATS without in_last.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package grant_dispatch_pkg:
  - state_e enum (IDLE, XFER, DRAIN)
  - PORT_IDX_W function
  - stats counter width constant STAT_W=16
- One sub-module, onehot_to_idx: combinational one-hot-to-binary encoder plus an is_onehot flag. It is reused by the arbiter's track debug.

Test Plan:
- Reset with grant=0010 asserted: hold rst_n=0 for 2 cycles -> all outputs 0. Release -> sel=1, in_ready=0010 next cycle.
- grant=0100, port 2 sends 3 beats A,B,C with in_last on C, out_ready=1 -> out_data A,B,C on consecutive cycles, out_port=2, out_last only on C, burst_done with C, busy low the cycle after.
- MAX_BEATS=8, port 0 streams 10 beats without last -> 8 beats out, 8th has out_last=1, burst_done pulses. Beats 9-10 stall until port 0 is granted again.
- out_ready toggles 1,0,0,1 during a port-3 burst -> out_data stable while stalled, in_ready[3]=0 while out_valid&&!out_ready, no beat lost or duplicated.
- grant=0110 in IDLE -> grant_err pulses 1 cycle, state stays IDLE, in_ready=0. A following grant=1000 is accepted normally.
- Arbiter-style rotation: grants 0001,0010,0100,1000 with 2-beat bursts each -> out_port sequence 0,0,1,1,2,2,3,3. With GRANT_DISPATCH_STATS_EN, stat_bursts=1 per port and stat_forced=0.
